// File: rtl/syzygy_adc_lane_tx.sv
// LTC2264-12 style transmit framer: 2 channels x 2 lanes, 16-bit serialization mode,
// emitting 4-bit words per divided clock for external 4:1 DDR output serializers.

package syzygy_adc_lane_tx_pkg;
  localparam int unsigned SAMPLE_W = 12;
  localparam int unsigned NIB_W    = 4;
  localparam int unsigned LANE_W   = 8;

  // One sample pair as carried on the input handshake and held in hold/tx
  typedef struct packed {
    logic [SAMPLE_W-1:0] ch1;
    logic [SAMPLE_W-1:0] ch2;
  } sample_pair_t;

  // Which half of the 8-bit lane frame goes out on the next edge
  typedef enum logic {
    PH_FIRST  = 1'b0,
    PH_SECOND = 1'b1
  } phase_t;
endpackage

module syzygy_adc_lane_tx
  import syzygy_adc_lane_tx_pkg::*;
#(
  parameter int unsigned UFLOW_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                pattern_sel,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_ch1,
  input  logic [SAMPLE_W-1:0] s_ch2,
  output logic [NIB_W-1:0]    out_ch1a_nib,
  output logic [NIB_W-1:0]    out_ch1b_nib,
  output logic [NIB_W-1:0]    out_ch2a_nib,
  output logic [NIB_W-1:0]    out_ch2b_nib,
  output logic [NIB_W-1:0]    out_fr_nib,
  output logic [NIB_W-1:0]    out_dco_nib,
  input  logic                underflow_clear,
  output logic [UFLOW_W-1:0]  underflow_count
);

  localparam logic [NIB_W-1:0] FR_FIRST    = 4'b1111;
  localparam logic [NIB_W-1:0] FR_SECOND   = 4'b0000;
  localparam logic [NIB_W-1:0] DCO_PATTERN = 4'b1010;

  // Lane A carries the odd data bits, MSB first, padded with two zeros
  function automatic logic [LANE_W-1:0] lane_odd(input logic [SAMPLE_W-1:0] d);
    return {d[11], d[9], d[7], d[5], d[3], d[1], 2'b00};
  endfunction

  // Lane B carries the even data bits, MSB first, padded with two zeros
  function automatic logic [LANE_W-1:0] lane_even(input logic [SAMPLE_W-1:0] d);
    return {d[10], d[8], d[6], d[4], d[2], d[0], 2'b00};
  endfunction

  phase_t              phase_q,      phase_d;
  sample_pair_t        hold_q,       hold_d;
  logic                hold_valid_q, hold_valid_d;
  sample_pair_t        tx_q,         tx_d;
  logic [SAMPLE_W-1:0] ramp_q,       ramp_d;
  logic [UFLOW_W-1:0]  uflow_q,      uflow_d;
  logic [NIB_W-1:0]    ch1a_q, ch1a_d, ch1b_q, ch1b_d;
  logic [NIB_W-1:0]    ch2a_q, ch2a_d, ch2b_q, ch2b_d;
  logic [NIB_W-1:0]    fr_q,   fr_d,   dco_q,  dco_d;

  logic [LANE_W-1:0]   w_ch1a, w_ch1b, w_ch2a, w_ch2b;
  logic                accept_c;

  // Lane words of the sample currently being framed
  assign w_ch1a = lane_odd(tx_q.ch1);
  assign w_ch1b = lane_even(tx_q.ch1);
  assign w_ch2a = lane_odd(tx_q.ch2);
  assign w_ch2b = lane_even(tx_q.ch2);

  // Hold slot is free when empty or when it drains into tx on this edge; no accepts in reset
  assign s_ready  = ~reset & enable & ~pattern_sel & (~hold_valid_q | (phase_q == PH_SECOND));
  assign accept_c = s_valid & s_ready;

  // Next-state and next-output logic for the frame sequencer
  always_comb begin
    phase_d      = PH_FIRST;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    tx_d         = tx_q;
    ramp_d       = ramp_q;
    uflow_d      = uflow_q;
    ch1a_d       = '0;
    ch1b_d       = '0;
    ch2a_d       = '0;
    ch2b_d       = '0;
    fr_d         = '0;
    dco_d        = '0;

    if (enable) begin
      dco_d = DCO_PATTERN;
      case (phase_q)
        PH_FIRST: begin
          ch1a_d  = w_ch1a[LANE_W-1 -: NIB_W];
          ch1b_d  = w_ch1b[LANE_W-1 -: NIB_W];
          ch2a_d  = w_ch2a[LANE_W-1 -: NIB_W];
          ch2b_d  = w_ch2b[LANE_W-1 -: NIB_W];
          fr_d    = FR_FIRST;
          phase_d = PH_SECOND;
        end
        PH_SECOND: begin
          ch1a_d  = w_ch1a[NIB_W-1:0];
          ch1b_d  = w_ch1b[NIB_W-1:0];
          ch2a_d  = w_ch2a[NIB_W-1:0];
          ch2b_d  = w_ch2b[NIB_W-1:0];
          fr_d    = FR_SECOND;
          phase_d = PH_FIRST;
          if (pattern_sel) begin
            tx_d.ch1 = ramp_q;
            tx_d.ch2 = ~ramp_q;
            ramp_d   = ramp_q + SAMPLE_W'(1);
          end else if (hold_valid_q) begin
            tx_d         = hold_q;
            hold_valid_d = 1'b0;
          end else if (uflow_q != {UFLOW_W{1'b1}}) begin
            uflow_d = uflow_q + UFLOW_W'(1);
          end
        end
        default: phase_d = PH_FIRST;
      endcase
    end

    // A fresh accept refills the slot after any drain above
    if (accept_c) begin
      hold_d.ch1   = s_ch1;
      hold_d.ch2   = s_ch2;
      hold_valid_d = 1'b1;
    end

    if (underflow_clear) begin
      uflow_d = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q      <= PH_FIRST;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      tx_q         <= '0;
      ramp_q       <= '0;
      uflow_q      <= '0;
      ch1a_q       <= '0;
      ch1b_q       <= '0;
      ch2a_q       <= '0;
      ch2b_q       <= '0;
      fr_q         <= '0;
      dco_q        <= '0;
    end else begin
      phase_q      <= phase_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      tx_q         <= tx_d;
      ramp_q       <= ramp_d;
      uflow_q      <= uflow_d;
      ch1a_q       <= ch1a_d;
      ch1b_q       <= ch1b_d;
      ch2a_q       <= ch2a_d;
      ch2b_q       <= ch2b_d;
      fr_q         <= fr_d;
      dco_q        <= dco_d;
    end
  end

  assign out_ch1a_nib    = ch1a_q;
  assign out_ch1b_nib    = ch1b_q;
  assign out_ch2a_nib    = ch2a_q;
  assign out_ch2b_nib    = ch2b_q;
  assign out_fr_nib      = fr_q;
  assign out_dco_nib     = dco_q;
  assign underflow_count = uflow_q;

endmodule

// File: tb/tb_syzygy_adc_lane_tx.sv
// Self-checking bench for syzygy_adc_lane_tx: vector table, directed corner sequences,
// and randomized traffic against a frame-level reference model.

module tb_syzygy_adc_lane_tx;

  localparam int unsigned UW = 4;
  localparam int UF_MAX = (1 << UW) - 1;

  logic          clk = 1'b0;
  logic          reset, enable, pattern_sel, s_valid, s_ready, underflow_clear;
  logic [11:0]   s_ch1, s_ch2;
  logic [3:0]    out_ch1a_nib, out_ch1b_nib, out_ch2a_nib, out_ch2b_nib;
  logic [3:0]    out_fr_nib, out_dco_nib;
  logic [UW-1:0] underflow_count;

  syzygy_adc_lane_tx #(.UFLOW_W(UW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
    .s_valid(s_valid), .s_ready(s_ready), .s_ch1(s_ch1), .s_ch2(s_ch2),
    .out_ch1a_nib(out_ch1a_nib), .out_ch1b_nib(out_ch1b_nib),
    .out_ch2a_nib(out_ch2a_nib), .out_ch2b_nib(out_ch2b_nib),
    .out_fr_nib(out_fr_nib), .out_dco_nib(out_dco_nib),
    .underflow_clear(underflow_clear), .underflow_count(underflow_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (plain integers)
  int m_phase, m_hv, m_h1, m_h2, m_t1, m_t2, m_ramp, m_uf;
  int e_n[4];
  int e_fr, e_dco;
  bit last_acc;

  typedef struct {
    logic        rst, en, psel, vld, uclr;
    logic [11:0] c1, c2;
    logic [3:0]  x1a, x1b, x2a, x2b, xfr, xdco;
    int          xuf;
    logic        xrdy;
  } vec_t;
  vec_t vq[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // 8-bit lane word: six data bits taken two apart from the top, then two zero pads
  function automatic int lane_word(input int d, input int odd);
    int w, src;
    w = 0;
    for (int k = 0; k < 6; k++) begin
      src = (odd != 0) ? (11 - 2 * k) : (10 - 2 * k);
      if (((d >> src) & 1) != 0) w = w | (1 << (7 - k));
    end
    return w;
  endfunction

  // Recover a 12-bit sample from its lane A and lane B words
  function automatic int decode(input int a, input int b);
    int d;
    d = 0;
    for (int k = 0; k < 6; k++) begin
      if (((a >> (7 - k)) & 1) != 0) d = d | (1 << (11 - 2 * k));
      if (((b >> (7 - k)) & 1) != 0) d = d | (1 << (10 - 2 * k));
    end
    return d;
  endfunction

  function automatic int m_ready();
    return (!reset && enable && !pattern_sel && (m_hv == 0 || m_phase == 1)) ? 1 : 0;
  endfunction

  task automatic model_update(input bit r, input bit en, input bit ps, input bit v,
                              input bit uc, input int c1, input int c2);
    int words[4];
    bit acc;
    if (r) begin
      m_phase = 0; m_hv = 0; m_h1 = 0; m_h2 = 0; m_t1 = 0; m_t2 = 0; m_ramp = 0; m_uf = 0;
      for (int i = 0; i < 4; i++) e_n[i] = 0;
      e_fr = 0; e_dco = 0;
      return;
    end
    acc = en && !ps && (m_hv == 0 || m_phase == 1) && v;
    if (!en) begin
      for (int i = 0; i < 4; i++) e_n[i] = 0;
      e_fr = 0; e_dco = 0; m_phase = 0;
    end else begin
      words[0] = lane_word(m_t1, 1);
      words[1] = lane_word(m_t1, 0);
      words[2] = lane_word(m_t2, 1);
      words[3] = lane_word(m_t2, 0);
      e_dco = 4'b1010;
      if (m_phase == 0) begin
        for (int i = 0; i < 4; i++) e_n[i] = words[i] / 16;
        e_fr = 15; m_phase = 1;
      end else begin
        for (int i = 0; i < 4; i++) e_n[i] = words[i] % 16;
        e_fr = 0; m_phase = 0;
        if (ps) begin
          m_t1 = m_ramp; m_t2 = 4095 - m_ramp; m_ramp = (m_ramp + 1) % 4096;
        end else if (m_hv != 0) begin
          m_t1 = m_h1; m_t2 = m_h2; m_hv = 0;
        end else if (m_uf < UF_MAX) begin
          m_uf = m_uf + 1;
        end
      end
    end
    if (acc) begin
      m_h1 = c1; m_h2 = c2; m_hv = 1;
    end
    if (uc) m_uf = 0;
  endtask

  task automatic compare_model(input string tag);
    check({tag, " ch1a"}, int'(out_ch1a_nib), e_n[0]);
    check({tag, " ch1b"}, int'(out_ch1b_nib), e_n[1]);
    check({tag, " ch2a"}, int'(out_ch2a_nib), e_n[2]);
    check({tag, " ch2b"}, int'(out_ch2b_nib), e_n[3]);
    check({tag, " fr"},   int'(out_fr_nib),   e_fr);
    check({tag, " dco"},  int'(out_dco_nib),  e_dco);
    check({tag, " uflow"}, int'(underflow_count), m_uf);
    check({tag, " ready"}, int'(s_ready), m_ready());
  endtask

  // One clock: capture inputs and handshake before the edge, sample outputs #1 after it
  task automatic step(input bit use_model, input string tag);
    bit r, en, ps, v, uc;
    int c1, c2;
    @(negedge clk);
    r = reset; en = enable; ps = pattern_sel; v = s_valid; uc = underflow_clear;
    c1 = int'(s_ch1); c2 = int'(s_ch2);
    last_acc = s_ready && s_valid;
    @(posedge clk);
    #1;
    if (use_model) begin
      model_update(r, en, ps, v, uc, c1, c2);
      compare_model(tag);
    end
  endtask

  // Two model-checked clocks from phase 0; returns the decoded channel samples
  task automatic frame(input string tag, output int d1, output int d2);
    int a1, b1, a2, b2;
    step(1, tag);
    a1 = int'(out_ch1a_nib) * 16; b1 = int'(out_ch1b_nib) * 16;
    a2 = int'(out_ch2a_nib) * 16; b2 = int'(out_ch2b_nib) * 16;
    step(1, tag);
    a1 = a1 + int'(out_ch1a_nib); b1 = b1 + int'(out_ch1b_nib);
    a2 = a2 + int'(out_ch2a_nib); b2 = b2 + int'(out_ch2b_nib);
    d1 = decode(a1, b1);
    d2 = decode(a2, b2);
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; pattern_sel = 1'b0; s_valid = 1'b0; underflow_clear = 1'b0;
    s_ch1 = '0; s_ch2 = '0;
    step(1, "reset");
    reset = 1'b0;
  endtask

  task automatic add_vec(input logic rst, input logic en, input logic ps, input logic vld,
                         input logic uc, input logic [11:0] c1, input logic [11:0] c2,
                         input logic [3:0] a1, input logic [3:0] b1, input logic [3:0] a2,
                         input logic [3:0] b2, input logic [3:0] fr, input logic [3:0] dco,
                         input int uf, input logic rdy);
    vec_t v;
    v.rst = rst; v.en = en; v.psel = ps; v.vld = vld; v.uclr = uc; v.c1 = c1; v.c2 = c2;
    v.x1a = a1; v.x1b = b1; v.x2a = a2; v.x2b = b2; v.xfr = fr; v.xdco = dco;
    v.xuf = uf; v.xrdy = rdy;
    vq.push_back(v);
  endtask

  initial begin
    int d1, d2, nxt;
    int got_q[$];

    reset = 1'b1; enable = 1'b0; pattern_sel = 1'b0; s_valid = 1'b0;
    underflow_clear = 1'b0; s_ch1 = '0; s_ch2 = '0;

    // Vector table: single ABC/555 transfer, underflow, clear-on-increment, disable, restart
    //       rst en ps vld uc  ch1      ch2      1a   1b   2a   2b   fr   dco  uf rdy
    add_vec(1, 0, 0, 0, 0, 12'h000, 12'h000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);
    add_vec(0, 1, 0, 1, 0, 12'hABC, 12'h555, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hA, 0, 1);
    add_vec(0, 1, 0, 0, 0, 12'h000, 12'h000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hA, 0, 1);
    add_vec(0, 1, 0, 0, 0, 12'h000, 12'h000, 4'hF, 4'h1, 4'h0, 4'hF, 4'hF, 4'hA, 0, 1);
    add_vec(0, 1, 0, 0, 0, 12'h000, 12'h000, 4'h8, 4'h8, 4'h0, 4'hC, 4'h0, 4'hA, 1, 1);
    add_vec(0, 1, 0, 0, 0, 12'h000, 12'h000, 4'hF, 4'h1, 4'h0, 4'hF, 4'hF, 4'hA, 1, 1);
    add_vec(0, 1, 0, 0, 1, 12'h000, 12'h000, 4'h8, 4'h8, 4'h0, 4'hC, 4'h0, 4'hA, 0, 1);
    add_vec(0, 0, 0, 0, 0, 12'h000, 12'h000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);
    add_vec(0, 1, 0, 0, 0, 12'h000, 12'h000, 4'hF, 4'h1, 4'h0, 4'hF, 4'hF, 4'hA, 0, 1);

    for (int i = 0; i < vq.size(); i++) begin
      reset = vq[i].rst; enable = vq[i].en; pattern_sel = vq[i].psel; s_valid = vq[i].vld;
      underflow_clear = vq[i].uclr; s_ch1 = vq[i].c1; s_ch2 = vq[i].c2;
      step(0, "vec");
      check($sformatf("vec%0d ch1a", i), int'(out_ch1a_nib), int'(vq[i].x1a));
      check($sformatf("vec%0d ch1b", i), int'(out_ch1b_nib), int'(vq[i].x1b));
      check($sformatf("vec%0d ch2a", i), int'(out_ch2a_nib), int'(vq[i].x2a));
      check($sformatf("vec%0d ch2b", i), int'(out_ch2b_nib), int'(vq[i].x2b));
      check($sformatf("vec%0d fr", i),   int'(out_fr_nib),   int'(vq[i].xfr));
      check($sformatf("vec%0d dco", i),  int'(out_dco_nib),  int'(vq[i].xdco));
      check($sformatf("vec%0d uflow", i), int'(underflow_count), vq[i].xuf);
      check($sformatf("vec%0d ready", i), int'(s_ready), int'(vq[i].xrdy));
    end

    // Full-rate streaming: frame i must carry sample i (frame 0 shows the reset value)
    do_reset();
    enable = 1'b1; s_valid = 1'b1; nxt = 1;
    for (int f = 0; f <= 100; f++) begin
      int a1, b1, a2, b2;
      a1 = 0; b1 = 0; a2 = 0; b2 = 0;
      for (int h = 0; h < 2; h++) begin
        s_ch1 = 12'(nxt); s_ch2 = 12'(nxt * 7);
        step(1, "stream");
        if (last_acc) nxt++;
        a1 = a1 * 16 + int'(out_ch1a_nib); b1 = b1 * 16 + int'(out_ch1b_nib);
        a2 = a2 * 16 + int'(out_ch2a_nib); b2 = b2 * 16 + int'(out_ch2b_nib);
      end
      got_q.push_back(decode(a1, b1));
      if (f > 0) check($sformatf("stream ch2 f%0d", f), decode(a2, b2), (f * 7) % 4096);
    end
    check("stream frames", got_q.size(), 101);
    for (int i = 0; i < got_q.size(); i++) check($sformatf("stream ch1 f%0d", i), got_q[i], i);
    check("stream uflow", int'(underflow_count), 0);
    s_valid = 1'b0;

    // One sample then starvation: repeats, counts 5, clear wins, then saturates
    do_reset();
    enable = 1'b1; s_valid = 1'b1; s_ch1 = 12'h123; s_ch2 = 12'h456;
    step(1, "uf accept");
    s_valid = 1'b0;
    step(1, "uf load");
    for (int f = 0; f < 5; f++) frame("uf starve", d1, d2);
    check("uf repeat ch1", d1, 'h123);
    check("uf repeat ch2", d2, 'h456);
    check("uf count5", int'(underflow_count), 5);
    step(1, "uf pre-clear");
    underflow_clear = 1'b1;
    step(1, "uf clear");
    underflow_clear = 1'b0;
    check("uf cleared", int'(underflow_count), 0);
    for (int f = 0; f < 20; f++) frame("uf sat", d1, d2);
    check("uf saturate", int'(underflow_count), UF_MAX);

    // Ramp pattern through the 0xFFF -> 0x000 wrap
    do_reset();
    enable = 1'b1; pattern_sel = 1'b1; s_valid = 1'b1;
    for (int f = 0; f < 4094; f++) frame("ramp run", d1, d2);
    for (int f = 0; f < 4; f++) begin
      frame("ramp wrap", d1, d2);
      check($sformatf("ramp ch1 f%0d", f), d1, (4093 + f) % 4096);
      check($sformatf("ramp ch2 f%0d", f), d2, 4095 - ((4093 + f) % 4096));
      check($sformatf("ramp ready f%0d", f), int'(s_ready), 0);
    end
    check("ramp uflow", int'(underflow_count), 0);
    pattern_sel = 1'b0; s_valid = 1'b0;

    // Disable during phase 1, re-enable restarts at the first nibble of retained tx
    do_reset();
    enable = 1'b1; s_valid = 1'b1; s_ch1 = 12'h9A5; s_ch2 = 12'h3C6;
    step(1, "dis accept");
    s_valid = 1'b0;
    step(1, "dis load");
    step(1, "dis first");
    enable = 1'b0;
    step(1, "dis off");
    check("dis fr", int'(out_fr_nib), 0);
    check("dis dco", int'(out_dco_nib), 0);
    check("dis ch1a", int'(out_ch1a_nib), 0);
    check("dis ready", int'(s_ready), 0);
    step(1, "dis off2");
    enable = 1'b1;
    step(1, "dis restart");
    check("restart fr", int'(out_fr_nib), 'hF);
    check("restart dco", int'(out_dco_nib), 'hA);
    check("restart ch1a", int'(out_ch1a_nib), 'hB);
    check("restart ch1b", int'(out_ch1b_nib), 'h4);
    step(1, "dis second");
    check("restart2 ch1a", int'(out_ch1a_nib), 'h0);
    check("restart2 ch1b", int'(out_ch1b_nib), 'hC);
    check("restart2 fr", int'(out_fr_nib), 'h0);

    // Reset mid-stream with a pending held sample: all cleared, sample discarded
    do_reset();
    enable = 1'b1; s_valid = 1'b1; s_ch1 = 12'h7E1; s_ch2 = 12'h1E7;
    step(1, "rst s0");
    s_ch1 = 12'h6D2; s_ch2 = 12'h2D6;
    step(1, "rst s1");
    check("rst pending", m_hv, 1);
    reset = 1'b1;
    step(1, "rst hit");
    check("rst fr", int'(out_fr_nib), 0);
    check("rst dco", int'(out_dco_nib), 0);
    check("rst ch2b", int'(out_ch2b_nib), 0);
    check("rst uflow", int'(underflow_count), 0);
    check("rst ready", int'(s_ready), 0);
    reset = 1'b0; s_valid = 1'b0;
    frame("rst after", d1, d2);
    check("rst after ch1", d1, 0);
    frame("rst after2", d1, d2);
    check("rst after2 ch1", d1, 0);
    check("rst after2 ch2", d2, 0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(0, 63) == 0);
      enable          = ($urandom_range(0, 7) != 0);
      pattern_sel     = ($urandom_range(0, 7) == 0);
      s_valid         = ($urandom_range(0, 1) == 1);
      underflow_clear = ($urandom_range(0, 31) == 0);
      s_ch1           = 12'($urandom);
      s_ch2           = 12'($urandom);
      step(1, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
